// File: rtl/cim_mem_access_arbiter_pkg.sv
// Shared CiM memory-access types: request-source enumeration, sizing constants, read tag.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cim_mem_access_arbiter_pkg;

    // Bit index of each requester on the MemAccessSignals bus; lower index = higher priority.
    typedef enum logic [2:0] {
        BUS_FSM       = 3'd0,
        DATA_FILL_FSM = 3'd1,
        LOGIC_FSM     = 3'd2,
        MAC           = 3'd3,
        LAYERNORM     = 3'd4,
        SOFTMAX       = 3'd5
    } MEM_ACCESS_SRC_T;

    localparam int MEM_ACCESS_SRC_NUM = 6;

    // Not a power of two, so the address bus has codes that do not map to a word.
    localparam int TEMP_RES_STORAGE_SIZE_CIM = 48;
    localparam int N_STORAGE                 = 16;

    // One entry of the read-tag pipeline: does this slot carry a read, and for whom.
    typedef struct packed {
        logic                          valid;
        logic [MEM_ACCESS_SRC_NUM-1:0] src;
    } MEM_RD_TAG_T;

endpackage

// File: rtl/cim_mem_access_stats.sv
// Saturating 32-bit counters of granted reads, granted writes and conflict cycles.
// Latency: each event is reflected in the counter one cycle after it is presented.
// Backpressure: none; counts every cycle, clr zeroes the bank (an event in the clr cycle still counts).
// The module only exists when CIM_MEM_ACCESS_STATS_EN is defined, so a default build
// carries no unused top-level module.
`ifdef CIM_MEM_ACCESS_STATS_EN
module cim_mem_access_stats (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        rd_inc,
    input  logic        wr_inc,
    input  logic        conflict_inc,
    output logic [31:0] stat_reads,
    output logic [31:0] stat_writes,
    output logic [31:0] stat_conflicts
);

    logic [2:0]  inc;
    logic [31:0] cnt_q [3];

    assign inc = {conflict_inc, wr_inc, rd_inc};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (clr)
                    cnt_q[i] <= {31'b0, inc[i]};
                else if (inc[i] && (cnt_q[i] != '1))
                    cnt_q[i] <= cnt_q[i] + 32'd1;
            end
        end
    end

    assign stat_reads     = cnt_q[0];
    assign stat_writes    = cnt_q[1];
    assign stat_conflicts = cnt_q[2];

endmodule
`endif

// File: rtl/cim_mem_access_arbiter.sv
// Fixed-priority arbiter of one-hot MemAccessSignals requests onto the single-port temp-result SRAM.
// Latency: grant same cycle; SRAM command T+1; read_valid T+2+RD_LAT.
// Backpressure: none; losers see grant=0 and must hold/retry, winner always completes in order.
//
// Ports: clk/rst_n (async active-low); read_req_src/write_req_src/addr_table/write_data per source;
// grant (combinational one-hot); read_valid/read_data/read_src response; sram_* command and
// sram_rdata return; err_multi_req/err_addr sticky flags cleared by err_clr.
// Build option CIM_MEM_ACCESS_STATS_EN adds stat_reads/stat_writes/stat_conflicts counters.
// NUM_SRC must equal MEM_ACCESS_SRC_NUM (the tag struct is sized by the package); RD_LAT is 1..2.
module cim_mem_access_arbiter
    import cim_mem_access_arbiter_pkg::*;
#(
    parameter int NUM_SRC = MEM_ACCESS_SRC_NUM,
    parameter int DEPTH   = TEMP_RES_STORAGE_SIZE_CIM,
    parameter int ADDR_W  = $clog2(TEMP_RES_STORAGE_SIZE_CIM),
    parameter int DATA_W  = N_STORAGE,
    parameter int RD_LAT  = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_SRC-1:0]        read_req_src,
    input  logic [NUM_SRC-1:0]        write_req_src,
    input  logic [NUM_SRC*ADDR_W-1:0] addr_table,
    input  logic [NUM_SRC*DATA_W-1:0] write_data,
    output logic [NUM_SRC-1:0]        grant,
    output logic                      read_valid,
    output logic [DATA_W-1:0]         read_data,
    output logic [NUM_SRC-1:0]        read_src,
    output logic                      sram_en,
    output logic                      sram_wen,
    output logic [ADDR_W-1:0]         sram_addr,
    output logic [DATA_W-1:0]         sram_wdata,
    input  logic [DATA_W-1:0]         sram_rdata,
    output logic                      err_multi_req,
    output logic                      err_addr,
    input  logic                      err_clr
`ifdef CIM_MEM_ACCESS_STATS_EN
    ,
    output logic [31:0]               stat_reads,
    output logic [31:0]               stat_writes,
    output logic [31:0]               stat_conflicts
`endif
);

    logic [NUM_SRC-1:0] req;
    logic [NUM_SRC-1:0] win;
    logic               any_req;
    logic               win_wr;
    logic               multi_pop;
    logic               multi;
    logic               in_range;
    logic [ADDR_W-1:0]  win_addr;
    logic [DATA_W-1:0]  win_wdata;
    MEM_RD_TAG_T        tag_in;

    // Read tag pipeline plus a parallel "out of range" bit so a bad-address read
    // still returns a (zero) response to its owner.
    MEM_RD_TAG_T        tag_q [RD_LAT+1];
    logic [RD_LAT:0]    oob_q;

    always_comb begin
        req       = read_req_src | write_req_src;
        any_req   = |req;
        // Isolate the lowest set bit: lowest index has the highest priority.
        win       = req & (~req + NUM_SRC'(1));
        // Clearing the lowest set bit leaves something only if two or more requested.
        multi_pop = (req & (req - NUM_SRC'(1))) != '0;
        // A source asserting read and write together is a protocol error; it is served as a write.
        multi     = multi_pop | (|(read_req_src & write_req_src));
        win_wr    = |(win & write_req_src);
        win_addr  = '0;
        win_wdata = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (win[i]) begin
                win_addr  = addr_table[i*ADDR_W +: ADDR_W];
                win_wdata = write_data[i*DATA_W +: DATA_W];
            end
        end
        in_range     = 32'(win_addr) < 32'(DEPTH);
        tag_in.valid = any_req & ~win_wr;
        tag_in.src   = win;
    end

    // Held at zero while reset is asserted so every output is quiet during reset.
    assign grant = rst_n ? win : '0;

    // SRAM command stage (cycle T+1).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sram_en    <= 1'b0;
            sram_wen   <= 1'b0;
            sram_addr  <= '0;
            sram_wdata <= '0;
        end else begin
            sram_en  <= any_req & in_range;
            sram_wen <= any_req & in_range & win_wr;
            if (any_req) begin
                sram_addr  <= win_addr;
                sram_wdata <= win_wdata;
            end
        end
    end

    // Tag stage i lines up with cycle T+1+i; stage RD_LAT meets the SRAM read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= RD_LAT; i++) tag_q[i] <= '0;
            oob_q <= '0;
        end else begin
            tag_q[0] <= tag_in;
            oob_q[0] <= tag_in.valid & ~in_range;
            for (int i = 1; i <= RD_LAT; i++) begin
                tag_q[i] <= tag_q[i-1];
                oob_q[i] <= oob_q[i-1];
            end
        end
    end

    // Response register; data and tag hold between pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            read_valid <= 1'b0;
            read_data  <= '0;
            read_src   <= '0;
        end else begin
            read_valid <= tag_q[RD_LAT].valid;
            if (tag_q[RD_LAT].valid) begin
                read_data <= oob_q[RD_LAT] ? '0 : sram_rdata;
                read_src  <= tag_q[RD_LAT].src;
            end
        end
    end

    // Sticky flags: a new error in the clear cycle keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_multi_req <= 1'b0;
            err_addr      <= 1'b0;
        end else begin
            err_multi_req <= multi | (err_multi_req & ~err_clr);
            err_addr      <= (any_req & ~in_range) | (err_addr & ~err_clr);
        end
    end

`ifdef CIM_MEM_ACCESS_STATS_EN
    cim_mem_access_stats u_stats (
        .clk            (clk),
        .rst_n          (rst_n),
        .clr            (err_clr),
        .rd_inc         (any_req & ~win_wr),
        .wr_inc         (any_req & win_wr),
        .conflict_inc   (multi_pop),
        .stat_reads     (stat_reads),
        .stat_writes    (stat_writes),
        .stat_conflicts (stat_conflicts)
    );
`endif

endmodule
